// File: rtl/carfield_regbus_tmo_demux.sv
// -----------------------------------------------------------------------------
// carfield_regbus_tmo_demux
//
// Register-bus demultiplexer with a per-access timeout. It accepts one register
// request at a time from the host bridge and decodes it against four 4 KiB
// regions:
//   index 0  PCRS      0x2001_0000  (always enabled)
//   index 1  PLL       0x2002_0000  (PllCfgEnable)
//   index 2  padframe  0x200A_0000  (PadframeCfgEnable)
//   index 3  L2 ECC    0x200B_0000  (L2EccCfgEnable)
// The access is forwarded to exactly one target, and a response is returned to
// the host. Decode misses return 0xBADC_AB1E with the error flag set.
//
// Optional feature: when the macro CARFIELD_REGBUS_TMO_EN is defined, a 16-bit
// counter ends an access that the target has held off for TimeoutCycles cycles.
// That access returns 0xDEAD_BEEF with the error flag set. When the macro is
// not defined, an access waits indefinitely for slv_ready_i.
//
// Ports
//   clk_i, rst_i       clock and synchronous active-high reset
//   req_*              host request channel (valid/ready, addr, write, wdata, wstrb)
//   rsp_*              host response channel (valid/ready, rdata, error)
//   slv_valid_o        one-hot target request
//   slv_ready_i        per-target completion; rdata and error valid in the same cycle
//   slv_addr_o         offset within the 4 KiB region
//   slv_write_o, slv_wdata_o, slv_wstrb_o   latched write attributes
//   slv_rdata_i, slv_error_i                per-target read data and error
// -----------------------------------------------------------------------------
module carfield_regbus_tmo_demux #(
  parameter bit          PllCfgEnable      = 1'b1,
  parameter bit          PadframeCfgEnable = 1'b1,
  parameter bit          L2EccCfgEnable    = 1'b1,
  parameter int unsigned TimeoutCycles     = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic             req_write_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_wstrb_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_error_o,
  output logic [3:0]       slv_valid_o,
  input  logic [3:0]       slv_ready_i,
  output logic [11:0]      slv_addr_o,
  output logic             slv_write_o,
  output logic [31:0]      slv_wdata_o,
  output logic [3:0]       slv_wstrb_o,
  input  logic [3:0][31:0] slv_rdata_i,
  input  logic [3:0]       slv_error_i
);

  localparam logic [19:0] PcrsBase     = 20'h2001_0;
  localparam logic [19:0] PllBase      = 20'h2002_0;
  localparam logic [19:0] PadframeBase = 20'h200A_0;
  localparam logic [19:0] L2EccBase    = 20'h200B_0;

  localparam logic [31:0] DecodeErrData  = 32'hBADC_AB1E;
  localparam logic [31:0] TimeoutErrData = 32'hDEAD_BEEF;

  // A timeout window shorter than two cycles, or one that does not fit the
  // 16-bit counter, is a configuration error.
  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
    $error("carfield_regbus_tmo_demux: TimeoutCycles must be within 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e     state_q;
  logic [1:0] target_q;

`ifdef CARFIELD_REGBUS_TMO_EN
  // The counter reaches this value during the last cycle a target may hold off.
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);
  logic [15:0] tmo_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Address decode of the incoming request
  // ---------------------------------------------------------------------------
  logic       dec_hit;
  logic [1:0] dec_idx;

  // NOTE: every signal is given a default before the if-chain. This prevents
  // a path from leaving the signal unassigned and inferring a latch.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 2'd0;
    if (req_addr_i[31:12] == PcrsBase) begin
      dec_hit = 1'b1;
      dec_idx = 2'd0;
    end else if (PllCfgEnable && req_addr_i[31:12] == PllBase) begin
      dec_hit = 1'b1;
      dec_idx = 2'd1;
    end else if (PadframeCfgEnable && req_addr_i[31:12] == PadframeBase) begin
      dec_hit = 1'b1;
      dec_idx = 2'd2;
    end else if (L2EccCfgEnable && req_addr_i[31:12] == L2EccBase) begin
      dec_hit = 1'b1;
      dec_idx = 2'd3;
    end
  end

  // The host may hand over a request only in IDLE, and never while reset is held.
  assign req_ready_o = (state_q == IDLE) && !rst_i;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // therefore update together at the edge, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      target_q    <= 2'd0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      slv_valid_o <= '0;
      slv_addr_o  <= '0;
      slv_write_o <= 1'b0;
      slv_wdata_o <= '0;
      slv_wstrb_o <= '0;
`ifdef CARFIELD_REGBUS_TMO_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            slv_addr_o  <= req_addr_i[11:0];
            slv_write_o <= req_write_i;
            slv_wdata_o <= req_wdata_i;
            slv_wstrb_o <= req_wstrb_i;
            target_q    <= dec_idx;
            if (dec_hit) begin
              slv_valid_o <= 4'b0001 << dec_idx;
              state_q     <= ACCESS;
`ifdef CARFIELD_REGBUS_TMO_EN
              tmo_cnt_q   <= '0;
`endif
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= DecodeErrData;
              rsp_error_o <= 1'b1;
              state_q     <= RESP;
            end
          end
        end

        ACCESS: begin
          // Only the selected target's ready matters. If ready and timeout
          // occur in the same cycle, ready is checked first and wins.
          if (slv_ready_i[target_q]) begin
            slv_valid_o <= '0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= slv_rdata_i[target_q];
            rsp_error_o <= slv_error_i[target_q];
            state_q     <= RESP;
          end
`ifdef CARFIELD_REGBUS_TMO_EN
          else if (tmo_cnt_q == TmoLast) begin
            slv_valid_o <= '0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= TimeoutErrData;
            rsp_error_o <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + 16'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_regbus_tmo_demux.sv
// -----------------------------------------------------------------------------
// tb_carfield_regbus_tmo_demux
//
// Testbench for carfield_regbus_tmo_demux. Two instances share all inputs:
//   dut_a  all regions enabled, TimeoutCycles = 16
//   dut_b  padframe disabled,   TimeoutCycles = 4
// The variable sel_b selects which instance's outputs are observed. Both
// instances are reset whenever the selection changes.
// When a request is issued, its expected response is pushed to a queue. The
// entry is popped and compared when the observed instance presents its response.
// -----------------------------------------------------------------------------
module tb_carfield_regbus_tmo_demux;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [31:0]      req_addr;
  logic             req_write;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic             rsp_ready;
  logic [3:0]       slv_ready;
  logic [3:0][31:0] slv_rdata;
  logic [3:0]       slv_error;

  always #5 clk = ~clk;

  // Outputs of each instance
  logic             a_req_ready, b_req_ready;
  logic             a_rsp_valid, b_rsp_valid;
  logic [31:0]      a_rsp_rdata, b_rsp_rdata;
  logic             a_rsp_error, b_rsp_error;
  logic [3:0]       a_slv_valid, b_slv_valid;
  logic [11:0]      a_slv_addr,  b_slv_addr;
  logic             a_slv_write, b_slv_write;
  logic [31:0]      a_slv_wdata, b_slv_wdata;
  logic [3:0]       a_slv_wstrb, b_slv_wstrb;

  carfield_regbus_tmo_demux #(
    .PllCfgEnable      (1'b1),
    .PadframeCfgEnable (1'b1),
    .L2EccCfgEnable    (1'b1),
    .TimeoutCycles     (16)
  ) dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (a_req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (a_rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (a_rsp_rdata),
    .rsp_error_o (a_rsp_error),
    .slv_valid_o (a_slv_valid),
    .slv_ready_i (slv_ready),
    .slv_addr_o  (a_slv_addr),
    .slv_write_o (a_slv_write),
    .slv_wdata_o (a_slv_wdata),
    .slv_wstrb_o (a_slv_wstrb),
    .slv_rdata_i (slv_rdata),
    .slv_error_i (slv_error)
  );

  carfield_regbus_tmo_demux #(
    .PllCfgEnable      (1'b1),
    .PadframeCfgEnable (1'b0),
    .L2EccCfgEnable    (1'b1),
    .TimeoutCycles     (4)
  ) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (b_req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (b_rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (b_rsp_rdata),
    .rsp_error_o (b_rsp_error),
    .slv_valid_o (b_slv_valid),
    .slv_ready_i (slv_ready),
    .slv_addr_o  (b_slv_addr),
    .slv_write_o (b_slv_write),
    .slv_wdata_o (b_slv_wdata),
    .slv_wstrb_o (b_slv_wstrb),
    .slv_rdata_i (slv_rdata),
    .slv_error_i (slv_error)
  );

  // Outputs of the instance currently under observation
  logic        sel_b;
  logic        req_ready, rsp_valid, rsp_error, slv_write;
  logic [31:0] rsp_rdata, slv_wdata;
  logic [3:0]  slv_valid, slv_wstrb;
  logic [11:0] slv_addr;

  always_comb begin
    req_ready = sel_b ? b_req_ready : a_req_ready;
    rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    rsp_rdata = sel_b ? b_rsp_rdata : a_rsp_rdata;
    rsp_error = sel_b ? b_rsp_error : a_rsp_error;
    slv_valid = sel_b ? b_slv_valid : a_slv_valid;
    slv_addr  = sel_b ? b_slv_addr  : a_slv_addr;
    slv_write = sel_b ? b_slv_write : a_slv_write;
    slv_wdata = sel_b ? b_slv_wdata : a_slv_wdata;
    slv_wstrb = sel_b ? b_slv_wstrb : a_slv_wstrb;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    slv_ready = '0;
    slv_rdata = '0;
    slv_error = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
  endtask

  // Checks that every output of the observed instance is zero
  task automatic check_all_zero(input string name);
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_error, slv_valid, slv_addr,
         slv_write, slv_wdata, slv_wstrb} !== '0)
      $display("FAIL %s: req_ready=%b rsp_valid=%b rdata=%h err=%b slv_valid=%b addr=%h write=%b wdata=%h wstrb=%h, required all zero",
               name, req_ready, rsp_valid, rsp_rdata, rsp_error, slv_valid, slv_addr,
               slv_write, slv_wdata, slv_wstrb);
    else pass_cnt++;
  endtask

  // Issues one request in the current cycle and records its expected response.
  // Returns at the falling edge of the following cycle (cycle 1).
  task automatic send_req(input logic [31:0] addr, input logic write,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rdata, input logic exp_err);
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL req_ready_idle: got %b, required 1 (addr %h)", req_ready, addr);
    else pass_cnt++;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = write;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits up to max_wait cycles for a response and compares it with the oldest
  // expectation. It then holds rsp_ready low for 'hold' cycles and completes
  // the handshake. Returns at the falling edge of the cycle after the handshake.
  task automatic get_rsp(input int max_wait, input int hold, input string name);
    exp_t e;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      total_cnt++;
      $display("FAIL %s_rsp_latency: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, n);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s_unexpected: response rdata=%h with no outstanding request", name, rsp_rdata);
      return;
    end
    e = sb_q.pop_front();
    total_cnt++;
    if (rsp_rdata !== e.rdata)
      $display("FAIL %s_rdata: got %h, required %h", name, rsp_rdata, e.rdata);
    else pass_cnt++;
    total_cnt++;
    if (rsp_error !== e.err)
      $display("FAIL %s_error: got %b, required %b", name, rsp_error, e.err);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_error !== e.err || req_ready !== 1'b0)
        $display("FAIL %s_hold%0d: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 name, i, rsp_valid, rsp_rdata, rsp_error, req_ready, e.rdata, e.err);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL %s_after_handshake: rsp_valid=%b req_ready=%b, required 0 1", name, rsp_valid, req_ready);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_pll_read();
    send_req(32'h2002_0004, 1'b0, '0, 4'h0, 32'h1234_5678, 1'b0);
    total_cnt++;
    if (slv_valid !== 4'b0010 || slv_addr !== 12'h004 || rsp_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL pll_cycle1: slv_valid=%b addr=%h rsp_valid=%b req_ready=%b, required 0010 004 0 0",
               slv_valid, slv_addr, rsp_valid, req_ready);
    else pass_cnt++;
    slv_ready    = 4'b0010;
    slv_rdata[1] = 32'h1234_5678;
    slv_error    = 4'b0000;
    @(negedge clk);
    slv_ready = '0;
    total_cnt++;
    if (slv_valid !== 4'b0000) $display("FAIL pll_cycle2_slv_valid: got %b, required 0000", slv_valid);
    else pass_cnt++;
    get_rsp(0, 0, "pll_read");
  endtask

  task automatic test_l2_write();
    send_req(32'h200B_0010, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b1);
    // Ready bits of the other targets are high while waiting and must be ignored.
    slv_ready = 4'b0111;
    slv_error = 4'b0111;
    slv_rdata = {32'h0, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    for (int c = 1; c < 5; c++) begin
      total_cnt++;
      if (slv_valid !== 4'b1000 || slv_addr !== 12'h010 || slv_write !== 1'b1 ||
          slv_wdata !== 32'hA5A5_A5A5 || slv_wstrb !== 4'hF || rsp_valid !== 1'b0)
        $display("FAIL l2_wait_cycle%0d: slv_valid=%b addr=%h write=%b wdata=%h wstrb=%h rsp_valid=%b, required 1000 010 1 a5a5a5a5 f 0",
                 c, slv_valid, slv_addr, slv_write, slv_wdata, slv_wstrb, rsp_valid);
      else pass_cnt++;
      @(negedge clk);
    end
    slv_ready    = 4'b1000;
    slv_error    = 4'b1000;
    slv_rdata[3] = 32'h0000_0000;
    total_cnt++;
    if (slv_wdata !== 32'hA5A5_A5A5) $display("FAIL l2_wdata_stable: got %h, required a5a5a5a5", slv_wdata);
    else pass_cnt++;
    @(negedge clk);
    slv_ready = '0;
    slv_error = '0;
    slv_rdata = '0;
    get_rsp(0, 0, "l2_write");
  endtask

  task automatic test_miss();
    send_req(32'h2003_0000, 1'b0, '0, 4'h0, 32'hBADC_AB1E, 1'b1);
    total_cnt++;
    if (slv_valid !== 4'b0000) $display("FAIL miss_slv_valid: got %b, required 0000", slv_valid);
    else pass_cnt++;
    get_rsp(0, 0, "miss_unmapped");
    // The padframe region is enabled on this instance and must decode.
    send_req(32'h200A_0008, 1'b0, '0, 4'h0, 32'h0F0F_0F0F, 1'b0);
    total_cnt++;
    if (slv_valid !== 4'b0100 || slv_addr !== 12'h008)
      $display("FAIL padframe_hit: slv_valid=%b addr=%h, required 0100 008", slv_valid, slv_addr);
    else pass_cnt++;
    slv_ready    = 4'b0100;
    slv_rdata[2] = 32'h0F0F_0F0F;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 0, "padframe_read");
  endtask

  task automatic test_back_to_back();
    send_req(32'h2001_0013, 1'b0, '0, 4'h0, 32'h5555_0013, 1'b0);
    total_cnt++;
    if (slv_valid !== 4'b0001 || slv_addr !== 12'h013)
      $display("FAIL b2b_pcrs_sel: slv_valid=%b addr=%h, required 0001 013", slv_valid, slv_addr);
    else pass_cnt++;
    slv_ready    = 4'b0001;
    slv_rdata[0] = 32'h5555_0013;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 3, "b2b_first");
    // A new request is accepted immediately in the cycle after the handshake.
    send_req(32'h2002_0ffc, 1'b0, '0, 4'h0, 32'h7777_0FFC, 1'b0);
    slv_ready    = 4'b0010;
    slv_rdata[1] = 32'h7777_0FFC;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 0, "b2b_second");
  endtask

  task automatic test_reset_mid_access();
    send_req(32'h2002_0008, 1'b1, 32'h1357_9BDF, 4'h3, 32'h0, 1'b0);
    // The aborted access produces no response.
    void'(sb_q.pop_back());
    total_cnt++;
    if (slv_valid !== 4'b0010) $display("FAIL midrst_in_access: slv_valid=%b, required 0010", slv_valid);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst_outputs");
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL midrst_idle: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    else pass_cnt++;
    send_req(32'h2002_000c, 1'b0, '0, 4'h0, 32'h2468_ACE0, 1'b0);
    slv_ready    = 4'b0010;
    slv_rdata[1] = 32'h2468_ACE0;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 0, "midrst_next");
  endtask

  task automatic test_padframe_disabled();
    send_req(32'h200A_0000, 1'b0, '0, 4'h0, 32'hBADC_AB1E, 1'b1);
    total_cnt++;
    if (slv_valid !== 4'b0000) $display("FAIL padoff_slv_valid: got %b, required 0000", slv_valid);
    else pass_cnt++;
    get_rsp(0, 0, "padoff_miss");
  endtask

  task automatic test_timeout();
    int n;
`ifdef CARFIELD_REGBUS_TMO_EN
    send_req(32'h2001_0000, 1'b0, '0, 4'h0, 32'hDEAD_BEEF, 1'b1);
    n = 0;
    while (slv_valid === 4'b0001 && n < 20) begin
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (n !== 4) $display("FAIL tmo_valid_cycles: got %0d, required 4", n);
    else pass_cnt++;
    // A late ready after the timeout must not alter the response.
    slv_ready    = 4'b0001;
    slv_rdata[0] = 32'h1111_1111;
    get_rsp(0, 0, "tmo_expired");
    slv_ready = '0;
    // Ready arrives in the fourth (last) cycle and wins over the timeout.
    send_req(32'h2001_0004, 1'b0, '0, 4'h0, 32'hCAFE_0004, 1'b0);
    for (int c = 1; c < 4; c++) @(negedge clk);
    total_cnt++;
    if (slv_valid !== 4'b0001) $display("FAIL tmo_4th_cycle_valid: got %b, required 0001", slv_valid);
    else pass_cnt++;
    slv_ready    = 4'b0001;
    slv_rdata[0] = 32'hCAFE_0004;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 0, "tmo_ready_wins");
`else
    // Without the timeout feature, the access waits for as long as the target
    // holds off.
    send_req(32'h2001_0004, 1'b0, '0, 4'h0, 32'hCAFE_0004, 1'b0);
    n = 0;
    while (slv_valid === 4'b0001 && rsp_valid === 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (n !== 40) $display("FAIL notmo_wait: access ended after %0d cycles, required still waiting at 40", n);
    else pass_cnt++;
    slv_ready    = 4'b0001;
    slv_rdata[0] = 32'hCAFE_0004;
    @(negedge clk);
    slv_ready = '0;
    get_rsp(0, 0, "notmo_ready");
`endif
  endtask

  initial begin
    sel_b = 1'b0;
    test_reset();
    test_pll_read();
    test_l2_write();
    test_miss();
    test_back_to_back();
    test_reset_mid_access();
    sel_b = 1'b1;
    apply_reset();
    test_padframe_disabled();
    test_timeout();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
